// File: rtl/mmio_io_hub_pkg.sv
// Shared memory map, LED command layout, button status layout and LFSR step for the I/O hub.
// The address defaults and bit positions are also used by the assembler test sources.
package mmio_io_hub_pkg;

  localparam logic [11:0] RAND_ADDR_DEF = 12'd5;
  localparam logic [11:0] LED_ADDR_DEF  = 12'd6;
  localparam logic [11:0] BTN_ADDR_DEF  = 12'd7;

  localparam int LED_ON_BIT    = 0;
  localparam int LED_CH_LSB    = 1;
  localparam int BTN_LEVEL_LSB = 16;

  localparam logic [31:0] SEED_DEF  = 32'hACE1_2468;
  // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {RD_RAM, RD_RAND, RD_BTN} rd_sel_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/mmio_io_hub_btn_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced level and a
// one-cycle pulse registered on each debounced rising transition.
module mmio_io_hub_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The level only moves after DEBOUNCE_CYCLES consecutive samples disagree with it
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: LED channels with steady/timed-flash modes, debounced buttons with
// sticky press flags, and a reseedable 32-bit LFSR, all sitting in front of data RAM reads.
module mmio_io_hub
  import mmio_io_hub_pkg::*;
#(
  parameter int          NUM_CH          = 4,
  parameter int          CH_W            = 2,
  parameter logic [11:0] RAND_ADDR       = RAND_ADDR_DEF,
  parameter logic [11:0] LED_ADDR        = LED_ADDR_DEF,
  parameter logic [11:0] BTN_ADDR        = BTN_ADDR_DEF,
  parameter int          FLASH_CYCLES    = 25_000_000,
  parameter int          DEBOUNCE_CYCLES = 500_000,
  parameter logic [31:0] SEED            = SEED_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       mem_addr,
  input  logic              mem_wen,
  input  logic [31:0]       mem_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       mem_rdata,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] led
);

  localparam int TMR_W = $clog2(FLASH_CYCLES + 1);

  logic              led_hit;
  logic              rand_hit;
  logic              btn_hit;
  logic              cmd_on;
  logic              cmd_timed;
  logic [CH_W-1:0]   cmd_ch;
  logic [TMR_W-1:0]  timer [NUM_CH];
  logic [31:0]       lfsr;
  logic [31:0]       reseed;
  logic [NUM_CH-1:0] btn_level;
  logic [NUM_CH-1:0] btn_rise;
  logic [NUM_CH-1:0] btn_flag;
  logic [31:0]       btn_status;
  rd_sel_e           rd_sel;

  assign led_hit   = mem_wen && (mem_addr == LED_ADDR);
  assign rand_hit  = mem_wen && (mem_addr == RAND_ADDR);
  assign btn_hit   = mem_wen && (mem_addr == BTN_ADDR);
  assign cmd_on    = mem_wdata[LED_ON_BIT];
  assign cmd_ch    = mem_wdata[LED_CH_LSB +: CH_W];
  assign cmd_timed = mem_wdata[LED_CH_LSB + CH_W];
  assign reseed    = lfsr_step(lfsr) ^ mem_wdata;

  // A command to a channel wins over that channel's countdown; out-of-range channels match nothing
  always_ff @(posedge clock) begin
    if (reset) begin
      led <= '0;
      for (int i = 0; i < NUM_CH; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (led_hit && (int'(cmd_ch) == i)) begin
          if (cmd_timed && cmd_on) begin
            led[i]   <= 1'b1;
            timer[i] <= TMR_W'(FLASH_CYCLES);
          end else begin
            led[i]   <= cmd_on;
            timer[i] <= '0;
          end
        end else if (timer[i] != '0) begin
          timer[i] <= timer[i] - TMR_W'(1);
          if (timer[i] == TMR_W'(1)) led[i] <= 1'b0;
        end
      end
    end
  end

  // A reseed that would lock the LFSR at zero falls back to the seed
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (rand_hit) begin
      lfsr <= (reseed == 32'h0) ? SEED : reseed;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_btn
    mmio_io_hub_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock (clock),
      .reset (reset),
      .raw   (btn_raw[g]),
      .level (btn_level[g]),
      .rise  (btn_rise[g])
    );
  end

  // A new press in the same cycle as a clear keeps the flag set
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_flag <= '0;
    end else begin
      btn_flag <= (btn_flag & ~(btn_hit ? mem_wdata[NUM_CH-1:0] : '0)) | btn_rise;
    end
  end

  always_comb begin
    btn_status = '0;
    btn_status[BTN_LEVEL_LSB +: NUM_CH] = btn_level;
    btn_status[NUM_CH-1:0] = btn_flag;
  end

  always_comb begin
    rd_sel = RD_RAM;
    if (mem_addr == RAND_ADDR)     rd_sel = RD_RAND;
    else if (mem_addr == BTN_ADDR) rd_sel = RD_BTN;
  end

  always_comb begin
    case (rd_sel)
      RD_RAND: mem_rdata = lfsr;
      RD_BTN:  mem_rdata = btn_status;
      default: mem_rdata = ram_rdata;
    endcase
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Bench for mmio_io_hub: cycle-level reference model compared every cycle, plus directed
// scenarios with hand-computed expectations (flash length, debounce, flags, LFSR reseed, reset).
module tb_mmio_io_hub;

  localparam int          FLASH    = 8;
  localparam int          DEB      = 4;
  localparam logic [31:0] SEED_VAL = 32'hACE1_2468;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] mem_addr = 12'd0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] ram_rdata = 32'h1234_5678;
  logic [31:0] mem_rdata;
  logic [3:0]  btn_raw = 4'b0000;
  logic [3:0]  led;

  logic [11:0] w_addr = 12'd0;
  logic        w_wen = 1'b0;
  logic [31:0] w_wdata = 32'h0;
  logic [31:0] w_ram = 32'h0BAD_F00D;
  logic [31:0] w_rdata;
  logic [3:0]  w_led;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  mmio_io_hub #(.NUM_CH(4), .CH_W(2), .FLASH_CYCLES(FLASH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .ram_rdata(ram_rdata), .mem_rdata(mem_rdata),
    .btn_raw(btn_raw), .led(led)
  );

  // Second instance with a 3-bit channel field so out-of-range channel indices can be encoded
  mmio_io_hub #(.NUM_CH(4), .CH_W(3), .FLASH_CYCLES(FLASH), .DEBOUNCE_CYCLES(DEB)) dut_wide (
    .clock(clock), .reset(reset), .mem_addr(w_addr), .mem_wen(w_wen),
    .mem_wdata(w_wdata), .ram_rdata(w_ram), .mem_rdata(w_rdata),
    .btn_raw(4'b0000), .led(w_led)
  );

  // Reference model state
  bit          model_valid = 0;
  logic [31:0] m_lfsr;
  logic [3:0]  m_led, m_level, m_flag, m_rise;
  int          m_left [4];
  logic [31:0] m_hist [4];

  function automatic logic [31:0] model_lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      model_valid = 1;
      m_lfsr = SEED_VAL;
      m_led = 4'b0; m_level = 4'b0; m_flag = 4'b0; m_rise = 4'b0;
      for (int c = 0; c < 4; c++) begin m_left[c] = 0; m_hist[c] = 32'h0; end
    end else begin
      logic [31:0] nxt;
      nxt = model_lfsr_next(m_lfsr);
      if (mem_wen && mem_addr == 12'd5) begin
        nxt = nxt ^ mem_wdata;
        if (nxt == 32'h0) nxt = SEED_VAL;
      end
      m_lfsr = nxt;
      for (int c = 0; c < 4; c++) begin
        bit all_diff;
        m_hist[c] = {m_hist[c][30:0], btn_raw[c]};
        if (mem_wen && mem_addr == 12'd7 && mem_wdata[c]) m_flag[c] = 1'b0;
        if (m_rise[c]) m_flag[c] = 1'b1;
        m_rise[c] = 1'b0;
        all_diff = 1;
        for (int k = 2; k < DEB + 2; k++) if (m_hist[c][k] == m_level[c]) all_diff = 0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          m_rise[c] = m_level[c];
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (m_left[c] > 0) begin
          m_left[c]--;
          if (m_left[c] == 0) m_led[c] = 1'b0;
        end
      end
      if (mem_wen && mem_addr == 12'd6) begin
        int ch;
        ch = int'(mem_wdata[2:1]);
        if (mem_wdata[3] && mem_wdata[0]) begin m_led[ch] = 1'b1; m_left[ch] = FLASH; end
        else begin m_led[ch] = mem_wdata[0]; m_left[ch] = 0; end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_valid) begin
      logic [31:0] exp_rd;
      if (mem_addr == 12'd5)      exp_rd = m_lfsr;
      else if (mem_addr == 12'd7) exp_rd = ({28'h0, m_level} << 16) | {28'h0, m_flag};
      else                        exp_rd = ram_rdata;
      check_output("model_led", {28'h0, led}, {28'h0, m_led});
      check_output("model_rdata", mem_rdata, exp_rd);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic apply_stimulus(input logic [11:0] addr, input logic [31:0] data);
    mem_addr = addr; mem_wdata = data; mem_wen = 1'b1;
    tick(1);
    mem_wen = 1'b0; mem_wdata = 32'h0;
  endtask

  task automatic apply_wide(input logic [31:0] data);
    w_addr = 12'd6; w_wdata = data; w_wen = 1'b1;
    tick(1);
    w_wen = 1'b0; w_wdata = 32'h0;
  endtask

  task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] expected);
    mem_addr = addr;
    #1;
    check_output(name, mem_rdata, expected);
  endtask

  initial begin
    int cnt;
    tick(3);
    reset = 1'b0;

    read_check("rand_seed", 12'd5, 32'hACE1_2468);
    tick(1);
    read_check("rand_step1", 12'd5, 32'h5670_9234);
    check_output("rand_nonzero", {31'h0, mem_rdata != 32'h0}, 32'h1);

    apply_stimulus(12'd6, 32'h0000_000B);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!led[1]) break;
      cnt++;
      tick(1);
    end
    check_output("flash_len", cnt, FLASH);
    check_output("flash_off", {28'h0, led}, 32'h0);

    apply_stimulus(12'd6, 32'h0000_000B);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!led[1]) break;
      cnt++;
      if (i == 4) apply_stimulus(12'd6, 32'h0000_000B);
      else tick(1);
    end
    check_output("flash_rewrite_len", cnt, 13);

    apply_stimulus(12'd6, 32'h7);
    apply_stimulus(12'd6, 32'h1);
    check_output("led_steady", {28'h0, led}, 32'h9);
    apply_stimulus(12'd6, 32'h8);
    check_output("led_timed_off", {28'h0, led}, 32'h8);

    apply_wide(32'h5);
    check_output("wide_ch2_on", {28'h0, w_led}, 32'h4);
    apply_wide(32'hB);
    check_output("wide_ch5_ignored", {28'h0, w_led}, 32'h4);
    apply_wide(32'h1F);
    check_output("wide_ch7_ignored", {28'h0, w_led}, 32'h4);
    w_addr = 12'd9;
    #1;
    check_output("wide_ram_pass", w_rdata, 32'h0BAD_F00D);

    btn_raw[2] = 1'b1;
    tick(3);
    btn_raw[2] = 1'b0;
    tick(10);
    read_check("btn_glitch", 12'd7, 32'h0);
    btn_raw[2] = 1'b1;
    tick(10);
    read_check("btn_press", 12'd7, 32'h0004_0004);
    apply_stimulus(12'd7, 32'h4);
    read_check("btn_clear", 12'd7, 32'h0004_0000);
    btn_raw[2] = 1'b0;
    tick(10);
    read_check("btn_release", 12'd7, 32'h0);
    btn_raw[2] = 1'b1;
    tick(6);
    apply_stimulus(12'd7, 32'h4);
    read_check("btn_set_wins", 12'd7, 32'h0004_0004);
    btn_raw[2] = 1'b0;
    tick(10);
    apply_stimulus(12'd7, 32'h4);
    read_check("btn_idle", 12'd7, 32'h0);

    apply_stimulus(12'd5, model_lfsr_next(m_lfsr));
    read_check("rand_zero_guard", 12'd5, 32'hACE1_2468);

    btn_raw[0] = 1'b1;
    tick(10);
    read_check("btn0_pending", 12'd7, 32'h0001_0001);
    apply_stimulus(12'd6, 32'h9);
    tick(2);
    check_output("flash_before_reset", {28'h0, led}, 32'h9);
    reset = 1'b1;
    tick(1);
    check_output("reset_led", {28'h0, led}, 32'h0);
    read_check("reset_btn", 12'd7, 32'h0);
    read_check("reset_rand", 12'd5, 32'hACE1_2468);
    btn_raw[0] = 1'b0;
    reset = 1'b0;
    tick(2);

    ram_rdata = 32'hDEAD_BEEF;
    read_check("ram_pass", 12'd9, 32'hDEAD_BEEF);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
